// File: rtl/regfile_wb_sched_if.sv
// regfile_wb_sched_if: bundles the two writeback sources, the issue port and the
// register-file write port of the writeback scheduler.
// master = execute/decode side driving requests, slave = the scheduler itself.
interface regfile_wb_sched_if #(
    parameter int NREGS = 32
);
    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [31:0]      alu_data;
    logic             alu_ready;

    logic             lsu_valid;
    logic [4:0]       lsu_rd;
    logic [31:0]      lsu_data;
    logic             lsu_ready;

    logic             iss_valid;
    logic [4:0]       iss_rs1;
    logic [4:0]       iss_rs2;
    logic             iss_ren1;
    logic             iss_ren2;
    logic [4:0]       iss_rd;
    logic             iss_wen;
    logic             iss_stall;

    logic             rf_wenb;
    logic [4:0]       rf_rd;
    logic [31:0]      rf_wdata;
    logic [NREGS-1:0] pending;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output iss_valid, iss_rs1, iss_rs2, iss_ren1, iss_ren2, iss_rd, iss_wen,
        input  alu_ready, lsu_ready, iss_stall,
        input  rf_wenb, rf_rd, rf_wdata, pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  iss_valid, iss_rs1, iss_rs2, iss_ren1, iss_ren2, iss_rd, iss_wen,
        output alu_ready, lsu_ready, iss_stall,
        output rf_wenb, rf_rd, rf_wdata, pending
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: arbitrates the ALU and LSU writebacks onto the single registered
// register-file write port and keeps a pending-write scoreboard that stalls issue on
// RAW/WAW hazards. x0 is never tracked and never written.
// Build option: define WBSCHED_RR_EN for round-robin arbitration between the two
// sources; when undefined the LSU has fixed priority and no pointer register exists.
module regfile_wb_sched #(
    parameter int NREGS = 32
) (
    input logic               clk,
    input logic               reset,
    regfile_wb_sched_if.slave wb
);

    logic             aluGrant;
    logic             lsuGrant;

    logic             rfWenb_q;
    logic             rfWenb_d;
    logic [4:0]       rfRd_q;
    logic [4:0]       rfRd_d;
    logic [31:0]      rfWdata_q;
    logic [31:0]      rfWdata_d;

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    logic             rawHazard;
    logic             wawHazard;
    logic             stall;
    logic             issueFire;

`ifdef WBSCHED_RR_EN
    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_LSU = 1'b1
    } lastGrant_e;

    lastGrant_e lastGrant_q;
    lastGrant_e lastGrant_d;

    // Contested cycles go to the source that lost the previous contest
    always_comb begin
        aluGrant    = 1'b0;
        lsuGrant    = 1'b0;
        lastGrant_d = lastGrant_q;
        if (wb.alu_valid && wb.lsu_valid) begin
            if (lastGrant_q == LAST_ALU) begin
                lsuGrant    = 1'b1;
                lastGrant_d = LAST_LSU;
            end else begin
                aluGrant    = 1'b1;
                lastGrant_d = LAST_ALU;
            end
        end else begin
            aluGrant = wb.alu_valid;
            lsuGrant = wb.lsu_valid;
        end
    end

    // Pointer starts as ALU-last so the LSU wins the first contest; it only moves on contests
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastGrant_q <= LAST_ALU;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end
`else
    // Fixed priority: the ALU only gets the port when the LSU has nothing to write
    always_comb begin
        lsuGrant = wb.lsu_valid;
        aluGrant = wb.alu_valid && !wb.lsu_valid;
    end
`endif

    assign wb.alu_ready = aluGrant;
    assign wb.lsu_ready = lsuGrant;

    // Capture the granted writeback; an x0 destination is consumed without a write
    always_comb begin
        rfWenb_d  = 1'b0;
        rfRd_d    = rfRd_q;
        rfWdata_d = rfWdata_q;
        if (lsuGrant) begin
            rfRd_d    = wb.lsu_rd;
            rfWdata_d = wb.lsu_data;
            rfWenb_d  = (wb.lsu_rd != 5'd0);
        end else if (aluGrant) begin
            rfRd_d    = wb.alu_rd;
            rfWdata_d = wb.alu_data;
            rfWenb_d  = (wb.alu_rd != 5'd0);
        end
    end

    // Registered write port; reset drops any write that is in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rfWenb_q  <= 1'b0;
            rfRd_q    <= 5'd0;
            rfWdata_q <= 32'd0;
        end else begin
            rfWenb_q  <= rfWenb_d;
            rfRd_q    <= rfRd_d;
            rfWdata_q <= rfWdata_d;
        end
    end

    // Hazards look only at registered pending bits, so a clear becomes visible a cycle later
    always_comb begin
        rawHazard = (wb.iss_ren1 && pending_q[wb.iss_rs1]) ||
                    (wb.iss_ren2 && pending_q[wb.iss_rs2]);
        wawHazard = wb.iss_wen && pending_q[wb.iss_rd];
        stall     = wb.iss_valid && (rawHazard || wawHazard);
        issueFire = wb.iss_valid && !stall;
    end

    assign wb.iss_stall = stall;

    // Committed writes clear their bit; a new producer issued the same cycle re-sets it
    always_comb begin
        pending_d = pending_q;
        if (rfWenb_q) begin
            pending_d[rfRd_q] = 1'b0;
        end
        if (issueFire && wb.iss_wen && (wb.iss_rd != 5'd0)) begin
            pending_d[wb.iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign wb.rf_wenb  = rfWenb_q;
    assign wb.rf_rd    = rfRd_q;
    assign wb.rf_wdata = rfWdata_q;
    assign wb.pending  = pending_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: drives random and directed writeback/issue traffic into the
// writeback scheduler; a queue of expected register-file writes is filled as sources
// are accepted and drained by an independent monitor on the write port.
module tb_regfile_wb_sched;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    regfile_wb_sched_if wbIf ();

    regfile_wb_sched #(.NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wbIf)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          due;
    } wbItem_t;

    wbItem_t     expQ[$];
    wbItem_t     monItem;
    int          cyc    = 0;
    int          checks = 0;
    int          passes = 0;

    // Stimulus requested by the current test step
    bit          aluV, lsuV, issV, ren1, ren2, wen;
    logic [4:0]  aluRd, lsuRd, rs1, rs2, issRd;
    logic [31:0] aluData, lsuData;

    // Reference model: set of outstanding destinations plus the write due to commit next
    logic [31:0] mPend;
    bit          mInflight;
    logic [4:0]  mInflightRd;
    bit          mLastAlu;

    // Count and report a single comparison
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Write-port monitor: every write must match the oldest expected one, on its due cycle
    always @(posedge clk) begin
        cyc++;
        #2;
        if (reset) begin
            if (wbIf.rf_wenb === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("wb_unexpected_write", 32'(wbIf.rf_wenb), 32'd0);
                end else begin
                    monItem = expQ.pop_front();
                    checkOutput("wb_rd", 32'(wbIf.rf_rd), 32'(monItem.rd));
                    checkOutput("wb_data", wbIf.rf_wdata, monItem.data);
                    checkOutput("wb_latency", cyc, monItem.due);
                end
            end else if (expQ.size() != 0 && expQ[0].due <= cyc) begin
                monItem = expQ.pop_front();
                checkOutput("wb_missing_write", 32'(wbIf.rf_wenb), 32'd1);
            end
        end
    end

    // Forget everything the model knows, as a reset does to the DUT
    task automatic resetModel();
        mPend     = 32'd0;
        mInflight = 1'b0;
        mLastAlu  = 1'b1;
        expQ.delete();
        aluV = 1'b0;
        lsuV = 1'b0;
        issV = 1'b0;
    endtask

    task automatic driveIdle();
        wbIf.alu_valid = 1'b0;
        wbIf.lsu_valid = 1'b0;
        wbIf.iss_valid = 1'b0;
        wbIf.iss_ren1  = 1'b0;
        wbIf.iss_ren2  = 1'b0;
        wbIf.iss_wen   = 1'b0;
    endtask

    task automatic setIssue(input bit v, input logic [4:0] r1, input bit e1,
                            input logic [4:0] r2, input bit e2,
                            input logic [4:0] d, input bit w);
        issV  = v;
        rs1   = r1;
        ren1  = e1;
        rs2   = r2;
        ren2  = e2;
        issRd = d;
        wen   = w;
    endtask

    // Record an accepted writeback; it should appear on the write port after the next edge
    task automatic acceptWb(input logic [4:0] rd, input logic [31:0] data);
        wbItem_t item;
        if (rd != 5'd0) begin
            item.rd   = rd;
            item.data = data;
            item.due  = cyc + 1;
            expQ.push_back(item);
            mInflight   = 1'b1;
            mInflightRd = rd;
        end
    endtask

    // One cycle: drive requests, check handshake/stall/scoreboard, then advance the model
    task automatic applyStimulus();
        bit          expAluRdy;
        bit          expLsuRdy;
        bit          expStall;
        bit          contested;
        logic [31:0] nextPend;
        @(negedge clk);
        wbIf.alu_valid = aluV;
        wbIf.alu_rd    = aluRd;
        wbIf.alu_data  = aluData;
        wbIf.lsu_valid = lsuV;
        wbIf.lsu_rd    = lsuRd;
        wbIf.lsu_data  = lsuData;
        wbIf.iss_valid = issV;
        wbIf.iss_rs1   = rs1;
        wbIf.iss_rs2   = rs2;
        wbIf.iss_ren1  = ren1;
        wbIf.iss_ren2  = ren2;
        wbIf.iss_rd    = issRd;
        wbIf.iss_wen   = wen;
        #1;
        contested = aluV && lsuV;
        if (contested) begin
`ifdef WBSCHED_RR_EN
            expLsuRdy = mLastAlu;
            expAluRdy = !mLastAlu;
`else
            expLsuRdy = 1'b1;
            expAluRdy = 1'b0;
`endif
        end else begin
            expAluRdy = aluV;
            expLsuRdy = lsuV;
        end
        expStall = issV && ((ren1 && mPend[rs1]) || (ren2 && mPend[rs2]) ||
                            (wen && mPend[issRd]));

        checkOutput("alu_ready", 32'(wbIf.alu_ready), 32'(expAluRdy));
        checkOutput("lsu_ready", 32'(wbIf.lsu_ready), 32'(expLsuRdy));
        checkOutput("iss_stall", 32'(wbIf.iss_stall), 32'(expStall));
        checkOutput("pending", wbIf.pending, mPend);

        nextPend = mPend;
        if (mInflight) nextPend[mInflightRd] = 1'b0;
        if (issV && !expStall && wen && issRd != 5'd0) nextPend[issRd] = 1'b1;
        mPend     = nextPend;
        mInflight = 1'b0;

        if (expLsuRdy) begin
            acceptWb(lsuRd, lsuData);
            lsuV = 1'b0;
        end else if (expAluRdy) begin
            acceptWb(aluRd, aluData);
            aluV = 1'b0;
        end
        if (contested) mLastAlu = expAluRdy;
        if (issV && !expStall) issV = 1'b0;
    endtask

    // Hold reset with random inputs and confirm every registered output reads zero
    task automatic resetDut(input int holdCycles);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < holdCycles; i++) begin
            wbIf.alu_valid = 1'($urandom_range(0, 1));
            wbIf.alu_rd    = 5'($urandom_range(0, 31));
            wbIf.alu_data  = $urandom();
            wbIf.lsu_valid = 1'($urandom_range(0, 1));
            wbIf.lsu_rd    = 5'($urandom_range(0, 31));
            wbIf.lsu_data  = $urandom();
            wbIf.iss_valid = 1'($urandom_range(0, 1));
            wbIf.iss_rs1   = 5'($urandom_range(0, 31));
            wbIf.iss_rs2   = 5'($urandom_range(0, 31));
            wbIf.iss_ren1  = 1'($urandom_range(0, 1));
            wbIf.iss_ren2  = 1'($urandom_range(0, 1));
            wbIf.iss_rd    = 5'($urandom_range(0, 31));
            wbIf.iss_wen   = 1'($urandom_range(0, 1));
            #1;
            checkOutput("reset_rf_wenb", 32'(wbIf.rf_wenb), 32'd0);
            checkOutput("reset_rf_rd", 32'(wbIf.rf_rd), 32'd0);
            checkOutput("reset_rf_wdata", wbIf.rf_wdata, 32'd0);
            checkOutput("reset_pending", wbIf.pending, 32'd0);
            @(negedge clk);
        end
        resetModel();
        driveIdle();
        reset = 1'b1;
    endtask

    // Short asynchronous reset pulse while a write is on the port
    task automatic midWriteReset();
        @(negedge clk);
        #1;
        checkOutput("pre_reset_rf_wenb", 32'(wbIf.rf_wenb), 32'd1);
        checkOutput("pre_reset_pending", wbIf.pending, 32'h0000_0F00);
        reset = 1'b0;
        #1;
        checkOutput("midreset_rf_wenb", 32'(wbIf.rf_wenb), 32'd0);
        checkOutput("midreset_rf_rd", 32'(wbIf.rf_rd), 32'd0);
        checkOutput("midreset_rf_wdata", wbIf.rf_wdata, 32'd0);
        checkOutput("midreset_pending", wbIf.pending, 32'd0);
        resetModel();
        driveIdle();
        #1;
        reset = 1'b1;
    endtask

    initial begin
        resetModel();
        setIssue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        aluRd = 5'd0; aluData = 32'd0; lsuRd = 5'd0; lsuData = 32'd0;
        driveIdle();

        resetDut(3);

        // First write after reset
        aluV = 1'b1; aluRd = 5'd5; aluData = 32'hDEAD_BEEF;
        applyStimulus();
        applyStimulus();
        applyStimulus();

        // Both sources contend for four cycles
        for (int i = 0; i < 4; i++) begin
            aluV = 1'b1; aluRd = 5'd3; aluData = 32'h11;
            lsuV = 1'b1; lsuRd = 5'd4; lsuData = 32'h22;
            applyStimulus();
        end
        lsuV = 1'b0;
        applyStimulus();
        applyStimulus();

        // RAW: producer of x7, dependent read, LSU commit of x7
        setIssue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        applyStimulus();
        setIssue(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        applyStimulus();
        lsuV = 1'b1; lsuRd = 5'd7; lsuData = 32'h55;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("raw_stall_released", 32'(wbIf.iss_stall), 32'd0);

        // New producer of x7 issued in the same cycle its old value commits
        lsuV = 1'b1; lsuRd = 5'd7; lsuData = 32'h77;
        applyStimulus();
        setIssue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        applyStimulus();
        applyStimulus();
        checkOutput("set_beats_clear", 32'(wbIf.pending[7]), 32'd1);

        // x0 is never tracked and never written
        setIssue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        applyStimulus();
        aluV = 1'b1; aluRd = 5'd0; aluData = 32'hFFFF_FFFF;
        applyStimulus();
        applyStimulus();
        checkOutput("x0_no_write", 32'(wbIf.rf_wenb), 32'd0);
        checkOutput("x0_pending", wbIf.pending, 32'h0000_0080);
        setIssue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
        applyStimulus();

        // WAW on x9: held until the x9 write commits
        setIssue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        applyStimulus();
        setIssue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        applyStimulus();
        applyStimulus();
        aluV = 1'b1; aluRd = 5'd9; aluData = 32'h0000_0909;
        for (int i = 0; i < 4; i++) applyStimulus();

        // Reset while a write is on the port with x8..x11 outstanding
        resetDut(2);
        for (int r = 8; r < 12; r++) begin
            setIssue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1);
            applyStimulus();
        end
        aluV = 1'b1; aluRd = 5'd3; aluData = 32'hCAFE_0003;
        applyStimulus();
        midWriteReset();
        applyStimulus();
        applyStimulus();

        // Randomized traffic with hazards concentrated on a few registers
        for (int n = 0; n < 400; n++) begin
            if (!aluV && $urandom_range(0, 99) < 60) begin
                aluV = 1'b1; aluRd = 5'($urandom_range(0, 7)); aluData = $urandom();
            end
            if (!lsuV && $urandom_range(0, 99) < 50) begin
                lsuV = 1'b1; lsuRd = 5'($urandom_range(0, 7)); lsuData = $urandom();
            end
            setIssue(1'($urandom_range(0, 99) < 70),
                     5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            applyStimulus();
        end

        // Drain any held requests, then everything expected must have been written
        issV = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus();
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
